// File: rtl/rf_multiport.sv
// rf_multiport: parametrised register file with NRD read ports, one write
// port, an optional hardwired zero register, optional write-to-read bypass,
// an optional registered read path and a one-entry-per-cycle clear sweep.
//
// Write handshake: a write is offered with we=1 and accepted only on an edge
// where wr_rdy=1 (no sweep running, RST low) and clr=0. A write that is not
// accepted is dropped, never held; the writer must watch wr_rdy.
module rf_multiport #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_OUT  = 0
) (
    input  logic                clk,
    input  logic                RST,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                clr,
    output logic                busy,
    output logic                wr_rdy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]     mem_q [NREG];

    logic                wr_acc;
    logic                mem_we;
    logic [AW-1:0]       mem_wa;
    logic [XLEN-1:0]     mem_wd;
    logic [NRD*XLEN-1:0] raw;

    // RST forces busy so nothing is accepted while the state is being reset.
    assign busy   = RST | (state_q == ST_CLEAR);
    assign wr_rdy = ~busy;

    // clr takes priority over a simultaneous write; writes to x0 are
    // discarded when the zero register is enabled.
    assign wr_acc = we & ~busy & ~clr & ~((ZERO_REG != 0) && (wa == '0));

    // Next-state logic of the clear sweep: clr (re)starts it at entry 0,
    // the last entry returns to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end else if (state_q == ST_CLEAR) begin
            if (cnt_q == AW'(NREG - 1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end
    end

    // State register; reset sends the block into a fresh sweep from entry 0.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Single array write port shared by the sweep and the architectural write.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa;
        mem_wd = wd;
        if (!RST && state_q == ST_CLEAR) begin
            mem_we = 1'b1;
            mem_wa = cnt_q;
            mem_wd = '0;
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
    end

    // Storage array; contents are only ever zeroed by the sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // Raw read value per port: sweep zero, then x0, then bypass, then array.
    always_comb begin
        raw = '0;
        for (int k = 0; k < NRD; k++) begin
            if (busy) begin
                raw[k*XLEN +: XLEN] = '0;
            end else if ((ZERO_REG != 0) && (ra[k*AW +: AW] == '0)) begin
                raw[k*XLEN +: XLEN] = '0;
            end else if ((BYPASS != 0) && wr_acc && (wa == ra[k*AW +: AW])) begin
                raw[k*XLEN +: XLEN] = wd;
            end else begin
                raw[k*XLEN +: XLEN] = mem_q[ra[k*AW +: AW]];
            end
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [NRD*XLEN-1:0] rd_q, rd_d;

            // Read data is captured every edge; no read enable.
            always_comb begin
                rd_d = raw;
            end

            // Output register, cleared by reset.
            always_ff @(posedge clk) begin
                if (RST) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_d;
                end
            end

            assign rd = rd_q;
        end else begin : g_comb_out
            assign rd = raw;
        end
    endgenerate

endmodule
